// File: rtl/wb_master_mux_pkg.sv
// wb_master_mux_pkg: burst codes, arbitration modes and FSM state shared by the Wishbone master mux.
package wb_master_mux_pkg;
  localparam logic [1:0] WB_BURST_NONE = 2'b00;
  localparam logic [1:0] WB_BURST_4 = 2'b01;
  localparam logic [1:0] WB_BURST_8 = 2'b10;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  typedef enum logic {IDLE, OWNED} mux_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: one-hot winner from a request vector, fixed priority or round-robin after ptr.
module wb_rr_pick #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          rr,
  output logic [N-1:0]  gnt
);
  int idx;
  // Scanning from lowest to highest priority lets the last hit win.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = rr ? (int'(ptr) + 1 + k) % N : k;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_master_mux.sv
// wb_master_mux: N-to-1 Wishbone master arbiter/mux; WB_MUX_TIMEOUT_EN adds a stall timeout that synthesizes m_err.
module wb_master_mux
  import wb_master_mux_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int SEL_W = 2,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_M-1:0]        m_cyc,
  input  logic [NUM_M-1:0]        m_stb,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M*ADDR_W-1:0] m_adr,
  input  logic [NUM_M*DATA_W-1:0] m_dat_w,
  input  logic [NUM_M*SEL_W-1:0]  m_sel,
  input  logic [NUM_M*2-1:0]      m_burst,
  output logic [NUM_M-1:0]        m_ack,
  output logic [NUM_M-1:0]        m_err,
  output logic [NUM_M-1:0]        m_rty,
  output logic [DATA_W-1:0]       m_dat_r,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [ADDR_W-1:0]       o_wb_adr,
  output logic [DATA_W-1:0]       o_wb_dat,
  output logic [SEL_W-1:0]        o_wb_sel,
  output logic [1:0]              o_wb_burst,
  input  logic [DATA_W-1:0]       i_wb_dat,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic                    i_wb_rty,
  output logic [NUM_M-1:0]        o_grant,
  output logic                    o_busy
);
  localparam int PW = $clog2(NUM_M);
  mux_state_e state;
  logic [NUM_M-1:0] grant, pick;
  logic [PW-1:0] ptr, pick_idx;
  logic raw_stb, resp, to_fire;
  wb_rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
    .req(m_cyc),
    .ptr(ptr),
    .rr(1'(ARB_MODE == ARB_RR)),
    .gnt(pick)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_M; i++) pick_idx = pick[i] ? PW'(i) : pick_idx;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= PW'(NUM_M - 1);
    end else if (state == IDLE) begin
      if (|m_cyc) begin
        state <= OWNED;
        grant <= pick;
        ptr <= pick_idx;
      end
    end else if (!o_wb_cyc) begin
      state <= IDLE;
      grant <= '0;
    end
  end
  // Grant is zero in IDLE, so the slave side falls to 0 with no extra gating.
  always_comb begin
    o_wb_cyc = 1'b0;
    raw_stb = 1'b0;
    o_wb_we = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_burst = WB_BURST_NONE;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant[i]) begin
        o_wb_cyc = m_cyc[i];
        raw_stb = m_stb[i];
        o_wb_we = m_we[i];
        o_wb_adr = m_adr[i*ADDR_W +: ADDR_W];
        o_wb_dat = m_dat_w[i*DATA_W +: DATA_W];
        o_wb_sel = m_sel[i*SEL_W +: SEL_W];
        o_wb_burst = m_burst[i*2 +: 2];
      end
    end
  end
  assign resp = i_wb_ack | i_wb_err | i_wb_rty;
  assign o_wb_stb = raw_stb & ~to_fire;
  assign m_ack = grant & {NUM_M{i_wb_ack}};
  assign m_err = grant & {NUM_M{i_wb_err | to_fire}};
  assign m_rty = grant & {NUM_M{i_wb_rty}};
  assign m_dat_r = i_wb_dat;
  assign o_grant = grant;
  assign o_busy = state == OWNED;
`ifdef WB_MUX_TIMEOUT_EN
  logic [15:0] tcnt;
  assign to_fire = raw_stb && !resp && tcnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tcnt <= '0;
    else tcnt <= (state != OWNED || resp || to_fire) ? 16'd0 : tcnt + 16'(raw_stb);
  end
`else
  logic [15:0] unused_timeout;
  assign to_fire = 1'b0;
  assign unused_timeout = 16'(TIMEOUT_CYC) ^ 16'(resp);
`endif
endmodule

// File: doc/wb_master_mux.md
WB_MASTER_MUX -- requirements
Module: wb_master_mux

Interface
REQ-001 SHALL have parameter NUM_M, default 2: number of Wishbone masters, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 24: Wishbone address width.
REQ-003 SHALL have parameter DATA_W, default 16: Wishbone data width.
REQ-004 SHALL have parameter SEL_W, default 2: byte-select width.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255: stall cycles before a synthesized error; range 1..65535.
REQ-007 SHALL have port i_clk, input, 1: the single clock; all logic on the rising edge.
REQ-008 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have ports m_cyc, m_stb, m_we, inputs, NUM_M each: per-master strobes, bit i = master i.
REQ-010 SHALL have ports m_adr (NUM_M*ADDR_W), m_dat_w (NUM_M*DATA_W), m_sel (NUM_M*SEL_W), m_burst (NUM_M*2), all inputs: flat per-master vectors; master i occupies slice i.
REQ-011 SHALL have ports m_ack, m_err, m_rty, outputs, NUM_M each: per-master responses.
REQ-012 SHALL have port m_dat_r, output, DATA_W: read data broadcast to all masters.
REQ-013 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we (1 each), o_wb_adr (ADDR_W), o_wb_dat (DATA_W), o_wb_sel (SEL_W), o_wb_burst (2), all outputs: slave side.
REQ-014 SHALL have ports i_wb_dat (DATA_W), i_wb_ack, i_wb_err, i_wb_rty (1 each), all inputs: slave responses.
REQ-015 SHALL have ports o_grant (NUM_M, one-hot) and o_busy (1), outputs: debug.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no owner) and OWNED (one owner, held in a registered one-hot grant).
REQ-017 In IDLE, when any m_cyc bit is high, the arbiter SHALL pick a winner per ARB_MODE and register it; state becomes OWNED at the next edge, so o_wb_cyc rises one cycle after request.
REQ-018 Round-robin SHALL search from last owner index +1, wrapping modulo NUM_M; the last-owner pointer SHALL reset to NUM_M-1, so master 0 wins the first tie.
REQ-019 In OWNED, ownership SHALL hold while the owner's m_cyc is high, including across bursts; there SHALL be no preemption.
REQ-020 When the owner's m_cyc is low in OWNED, the FSM SHALL enter IDLE at the next edge and clear grant, giving a minimum one-cycle gap between owners.
REQ-021 In OWNED, the slave-side outputs SHALL combinationally equal the owner's slice, and o_wb_cyc SHALL equal the owner's m_cyc.
REQ-022 In IDLE, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel and o_wb_burst SHALL be 0; o_wb_adr and o_wb_dat SHALL be 0.
REQ-023 i_wb_ack, i_wb_err and i_wb_rty SHALL route only to the owner; non-owners SHALL see 0.
REQ-024 m_burst encoding SHALL be 00 none, 01 4-beat, 10 8-beat, 11 reserved (passed through unchanged).
REQ-025 o_busy SHALL be high exactly in OWNED; o_grant SHALL equal the registered grant.

Reset
REQ-026 i_rst high SHALL force IDLE, grant 0, RR pointer NUM_M-1 and timeout counter 0 immediately, all slave-side strobes 0, and all m_ack, m_err and m_rty 0; mid-transaction reset SHALL abandon the transaction with no response.

Configuration
REQ-027 Macro WB_MUX_TIMEOUT_EN defined: a counter SHALL increment each cycle o_wb_stb is high with no ack, err or rty, and clear on any response or in IDLE; on reaching TIMEOUT_CYC it SHALL pulse the owner's m_err for one cycle, force o_wb_stb low that cycle, and clear.
REQ-028 Macro WB_MUX_TIMEOUT_EN undefined: there SHALL be no counter; m_err SHALL be pure passthrough, and TIMEOUT_CYC SHALL be ignored.

Structure
REQ-029 The shared package/include SHALL hold the burst-code constants (WB_BURST_NONE, WB_BURST_4, WB_BURST_8) and the ARB_MODE constants.
REQ-030 The winner-selection logic SHALL be one combinational sub-module, wb_rr_pick (request vector, pointer, mode → one-hot).

Verification
REQ-031 NUM_M=2, ARB_MODE=0, both m_cyc rise together at cycle 0 → o_grant=01 at cycle 1; master 1 granted 2 cycles after master 0 drops cyc.
REQ-032 NUM_M=4, ARB_MODE=1, m_cyc=1111 held, each owner drops cyc after 1 ack → grant order 0001, 0010, 0100, 1000, 0001.
REQ-033 Master 1 owner, 8-beat burst (m_burst=10), 8 acks while master 0 requests → no preemption; o_wb_burst=10 throughout; master 0 sees m_ack=0.
REQ-034 WB_MUX_TIMEOUT_EN, TIMEOUT_CYC=4, slave never acks → owner m_err pulses on the 4th stalled cycle for one cycle; counter restarts.
REQ-035 i_rst asserted mid-burst (cycle 3 of 8) → o_wb_cyc=0 and o_grant=0 in the same cycle, before any clock edge; after release, lowest-index requester is granted one cycle after request.
